// File: rtl/fifo.sv
// Single-clock 16x8 first-word-fall-through FIFO: register file plus pointer/flag control.
// r_data always shows the head entry; full/empty are registered and change only on clk.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Handshake: a push is taken when push=1 and full=0 at the edge; a pop is taken
  // when pop=1 and empty=0. Requests that are not taken are dropped without effect.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] wptr_next;
  logic [ADDR_WIDTH-1:0] rptr_next;
  logic                  push_ok;
  logic                  pop_ok;

  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign wptr_next = wptr + 1'b1;
  assign rptr_next = rptr + 1'b1;
  assign r_data    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) begin
        wptr <= wptr_next;
      end
      if (pop_ok) begin
        rptr <= rptr_next;
      end
      // Simultaneous push and pop keeps occupancy, so the flags hold.
      if (push_ok && !pop_ok) begin
        empty <= 1'b0;
        full  <= (wptr_next == rptr);
      end else if (pop_ok && !push_ok) begin
        full  <= 1'b0;
        empty <= (rptr_next == wptr);
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: queue-based occupancy model checked every cycle, plus directed
// vectors with hand-computed head values and flags.
module tb_fifo;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] w_data;
  logic       full;
  logic       empty;
  logic [7:0] r_data;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [7:0] model_q[$];

  fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .w_data (w_data),
    .full   (full),
    .empty  (empty),
    .r_data (r_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of at most 16 bytes; acceptance uses the pre-edge occupancy.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
    end else begin
      bit take_push;
      bit take_pop;
      take_push = push && (model_q.size() < 16);
      take_pop  = pop && (model_q.size() > 0);
      if (take_pop) void'(model_q.pop_front());
      if (take_push) model_q.push_back(w_data);
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("model_full", {31'd0, full}, {31'd0, model_q.size() == 16});
      check("model_empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
      if (model_q.size() > 0) check("model_r_data", {24'd0, r_data}, {24'd0, model_q[0]});
    end
  end

  // Driver: hold inputs across one rising edge, then release just after it
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    push   = p;
    pop    = q;
    w_data = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; w_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_full", {31'd0, full}, 32'd0);
    check("reset_r_data", {24'd0, r_data}, 32'd0);
    rst = 1'b0;
    started = 1;

    // Fill and ordering
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 5; i++) begin
      check("order_r_data", {24'd0, r_data}, i);
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("order_empty", {31'd0, empty}, 32'd1);

    // Full, ignored 17th push, drain
    for (int i = 0; i < 16; i++) begin
      check("fill_not_full", {31'd0, full}, 32'd0);
      cyc(1'b1, 1'b0, 8'(8'h10 + i));
    end
    check("full_after_16", {31'd0, full}, 32'd1);
    cyc(1'b1, 1'b0, 8'hAA);
    check("full_after_17th", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("drain_r_data", {24'd0, r_data}, 32'h10 + i);
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Simultaneous push and pop with one entry stored
    cyc(1'b1, 1'b0, 8'h05);
    for (int i = 1; i <= 10; i++) begin
      check("simul_r_data", {24'd0, r_data}, (i == 1) ? 32'h05 : i - 1);
      check("simul_empty", {31'd0, empty}, 32'd0);
      check("simul_full", {31'd0, full}, 32'd0);
      cyc(1'b1, 1'b1, 8'(i));
    end
    check("simul_last", {24'd0, r_data}, 32'd10);
    cyc(1'b0, 1'b1, 8'h00);
    check("simul_drained", {31'd0, empty}, 32'd1);

    // Push and pop while empty: only the push lands
    cyc(1'b1, 1'b1, 8'h33);
    check("pp_empty_flag", {31'd0, empty}, 32'd0);
    check("pp_empty_data", {24'd0, r_data}, 32'h33);
    cyc(1'b0, 1'b1, 8'h00);

    // Push and pop while full: only the pop lands, 0xBB is dropped
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    check("pp_full_before", {31'd0, full}, 32'd1);
    cyc(1'b1, 1'b1, 8'hBB);
    check("pp_full_after", {31'd0, full}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      check("pp_full_drain", {24'd0, r_data}, 32'h40 + i);
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("pp_full_empty", {31'd0, empty}, 32'd1);

    // Pop while empty must not move the read pointer
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    check("pop_empty_flag", {31'd0, empty}, 32'd1);
    cyc(1'b1, 1'b0, 8'h44);
    check("pop_empty_head", {24'd0, r_data}, 32'h44);
    cyc(1'b0, 1'b1, 8'h00);

    // Reset mid-operation discards contents
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h77);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check("midrst_empty", {31'd0, empty}, 32'd1);
    check("midrst_full", {31'd0, full}, 32'd0);
    check("midrst_r_data", {24'd0, r_data}, 32'd0);

    // Random traffic, phases biased toward filling then draining
    for (int i = 0; i < 200; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
          8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
